// File: rtl/sprite_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sprite_pkg
// Description : Constants, access encodings and scheduler state type shared
//               by the sprite update scheduler and its sub-blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    // Bytes per object-table entry; a slot index maps to index*OBJ_BYTES.
    localparam int OBJ_BYTES       = 4;
    // Byte address of the sprite-unit control register.
    localparam int CONTROL_ADDR    = 63;

    // Control register bit positions.
    localparam int BITMAP_WRITE_EN = 0;
    localparam int STAGING_READY   = 1;

    // Sprite-unit access-width encoding on *_write_n / *_read_n.
    localparam logic [1:0] ACC_BYTE = 2'b00;
    localparam logic [1:0] ACC_HALF = 2'b01;
    localparam logic [1:0] ACC_WORD = 2'b10;
    localparam logic [1:0] ACC_NONE = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } sched_state_e;

    // Byte address of an object-table slot.
    function automatic logic [5:0] slot_addr(input logic [5:0] idx);
        return 6'(idx * 6'(OBJ_BYTES));
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_update_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : sprite_update_scheduler_if
// Description : Command, host-port and sprite-unit bus signals of the sprite
//               update scheduler. The slave modport is the scheduler's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface sprite_update_scheduler_if #(
    parameter int MAX_SPRITES = 8
) ();
    localparam int IDX_W = $clog2(MAX_SPRITES);

    // Update command stream
    logic             cmd_valid;
    logic             cmd_ready;
    logic [IDX_W-1:0] cmd_index;
    logic [31:0]      cmd_data;

    // Direct host access port
    logic [5:0]       cpu_address;
    logic [31:0]      cpu_data_in;
    logic [1:0]       cpu_write_n;
    logic [1:0]       cpu_read_n;
    logic [31:0]      cpu_data_out;
    logic             cpu_data_ready;
    logic             cpu_busy;

    // Sprite-unit host bus
    logic [5:0]       spr_address;
    logic [31:0]      spr_data_in;
    logic [1:0]       spr_write_n;
    logic [1:0]       spr_read_n;
    logic [31:0]      spr_data_out;
    logic             spr_data_ready;

    modport slave (
        input  cmd_valid, cmd_index, cmd_data,
        output cmd_ready,
        input  cpu_address, cpu_data_in, cpu_write_n, cpu_read_n,
        output cpu_data_out, cpu_data_ready, cpu_busy,
        output spr_address, spr_data_in, spr_write_n, spr_read_n,
        input  spr_data_out, spr_data_ready
    );

    modport master (
        output cmd_valid, cmd_index, cmd_data,
        input  cmd_ready,
        output cpu_address, cpu_data_in, cpu_write_n, cpu_read_n,
        input  cpu_data_out, cpu_data_ready, cpu_busy,
        input  spr_address, spr_data_in, spr_write_n, spr_read_n,
        output spr_data_out, spr_data_ready
    );

endinterface
`default_nettype wire

// File: rtl/sprite_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sprite_cmd_fifo
// Description : Pending update-command queue. Power-of-two depth, pointer
//               based, with full/empty flags and an occupancy count.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_cmd_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  wire logic                       clk,
    input  wire logic                       rst_n,
    input  wire logic                       push,
    input  wire logic [WIDTH-1:0]           din,
    input  wire logic                       pop,
    output logic      [WIDTH-1:0]           dout,
    output logic                            full,
    output logic                            empty,
    output logic      [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             w_do_push;
    logic             w_do_pop;

    // Guard both ports so the pointers can never overrun or underrun.
    always_comb begin
        w_do_push = push && (count_q != (AW+1)'(DEPTH));
        w_do_pop  = pop  && (count_q != '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (w_do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({w_do_push, w_do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) mem_q[wr_ptr_q] <= din;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/sprite_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : sprite_update_scheduler
// Description : Queues sprite object-table updates and flushes them to the
//               sprite unit as one batch (word writes + control commit) when
//               the unit requests staging or the host asks for a commit.
//               While idle the host port passes straight through.
// Revision    : 1.0 - initial release
// ============================================================================
module sprite_update_scheduler #(
    parameter int MAX_SPRITES  = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int CONTROL_ADDR = sprite_pkg::CONTROL_ADDR
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    sprite_update_scheduler_if.slave   bus,
    input  wire logic                  commit_req,
    input  wire logic                  user_interrupt,
    input  wire logic                  bitmap_wr_en,
    output logic      [7:0]            underrun_count,
    output logic      [7:0]            batch_count
);
    import sprite_pkg::*;

    localparam int IDX_W = $clog2(MAX_SPRITES);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int FW    = IDX_W + 32;

    sched_state_e     state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic [5:0]       spr_addr_q, spr_addr_d;
    logic [31:0]      spr_wdata_q, spr_wdata_d;
    logic [1:0]       spr_wr_n_q, spr_wr_n_d;
    logic [1:0]       spr_rd_n_q, spr_rd_n_d;
    logic [7:0]       underrun_q, underrun_d;
    logic [7:0]       batch_q, batch_d;

    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic [FW-1:0]    w_fifo_dout;
    logic             w_pop;
    logic             w_push;
    logic [IDX_W-1:0] w_head_idx;
    logic [31:0]      w_head_data;
    logic             w_trigger;
    logic [31:0]      w_ctrl_word;

    assign w_push      = bus.cmd_valid && !w_full;
    assign w_head_idx  = w_fifo_dout[FW-1:32];
    assign w_head_data = w_fifo_dout[31:0];
    assign w_trigger   = (user_interrupt || commit_req) && !w_empty;

    sprite_cmd_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .din   ({bus.cmd_index, bus.cmd_data}),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Control byte: staging-ready set, bitmap write enable preserved.
    always_comb begin
        w_ctrl_word                  = '0;
        w_ctrl_word[STAGING_READY]   = 1'b1;
        w_ctrl_word[BITMAP_WRITE_EN] = bitmap_wr_en;
    end

    // Next-state, batch sequencing and the registered sprite-bus values.
    // The bus registers are loaded one cycle ahead of the cycle they drive.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        spr_addr_d  = spr_addr_q;
        spr_wdata_d = spr_wdata_q;
        spr_wr_n_d  = spr_wr_n_q;
        spr_rd_n_d  = spr_rd_n_q;
        underrun_d  = underrun_q;
        batch_d     = batch_q;
        w_pop       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_trigger) begin
                    // Batch size is frozen here; later pushes wait.
                    state_d     = ST_DRAIN;
                    remain_d    = w_count - 1'b1;
                    w_pop       = 1'b1;
                    spr_addr_d  = slot_addr(6'(w_head_idx));
                    spr_wdata_d = w_head_data;
                    spr_wr_n_d  = ACC_WORD;
                    spr_rd_n_d  = ACC_NONE;
                end else if (user_interrupt && !commit_req && w_empty
                             && underrun_q != 8'hFF) begin
                    underrun_d = underrun_q + 8'd1;
                end
            end
            ST_DRAIN: begin
                if (remain_q != '0) begin
                    remain_d    = remain_q - 1'b1;
                    w_pop       = 1'b1;
                    spr_addr_d  = slot_addr(6'(w_head_idx));
                    spr_wdata_d = w_head_data;
                    spr_wr_n_d  = ACC_WORD;
                end else begin
                    state_d     = ST_COMMIT;
                    spr_addr_d  = 6'(CONTROL_ADDR);
                    spr_wdata_d = w_ctrl_word;
                    spr_wr_n_d  = ACC_BYTE;
                end
            end
            ST_COMMIT: begin
                state_d     = ST_IDLE;
                spr_addr_d  = '0;
                spr_wdata_d = '0;
                spr_wr_n_d  = ACC_NONE;
                spr_rd_n_d  = ACC_NONE;
                batch_d     = batch_q + 8'd1;
            end
            default: begin
                state_d    = ST_IDLE;
                spr_wr_n_d = ACC_NONE;
                spr_rd_n_d = ACC_NONE;
            end
        endcase
    end

    // Scheduler state, counters and registered bus drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remain_q    <= '0;
            spr_addr_q  <= '0;
            spr_wdata_q <= '0;
            spr_wr_n_q  <= ACC_NONE;
            spr_rd_n_q  <= ACC_NONE;
            underrun_q  <= '0;
            batch_q     <= '0;
        end else begin
            state_q     <= state_d;
            remain_q    <= remain_d;
            spr_addr_q  <= spr_addr_d;
            spr_wdata_q <= spr_wdata_d;
            spr_wr_n_q  <= spr_wr_n_d;
            spr_rd_n_q  <= spr_rd_n_d;
            underrun_q  <= underrun_d;
            batch_q     <= batch_d;
        end
    end

    // Bus ownership: host passes through only while idle.
    always_comb begin
        bus.cpu_data_out   = '0;
        bus.cpu_data_ready = 1'b0;
        bus.spr_address    = spr_addr_q;
        bus.spr_data_in    = spr_wdata_q;
        bus.spr_write_n    = spr_wr_n_q;
        bus.spr_read_n     = spr_rd_n_q;
        if (state_q == ST_IDLE) begin
            bus.spr_address    = bus.cpu_address;
            bus.spr_data_in    = bus.cpu_data_in;
            bus.spr_write_n    = bus.cpu_write_n;
            bus.spr_read_n     = bus.cpu_read_n;
            bus.cpu_data_out   = bus.spr_data_out;
            bus.cpu_data_ready = bus.spr_data_ready;
        end
    end

    assign bus.cpu_busy  = (state_q != ST_IDLE);
    assign bus.cmd_ready = !w_full;
    assign underrun_count = underrun_q;
    assign batch_count    = batch_q;

endmodule
`default_nettype wire

// File: tb/tb_sprite_update_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_sprite_update_scheduler
// Description : Directed self-checking bench for sprite_update_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sprite_update_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       commit_req;
    logic       user_interrupt;
    logic       bitmap_wr_en;
    logic [7:0] underrun_count;
    logic [7:0] batch_count;

    int n_checks = 0;
    int n_pass   = 0;

    sprite_update_scheduler_if #(.MAX_SPRITES(8)) bus ();

    sprite_update_scheduler #(
        .MAX_SPRITES  (8),
        .FIFO_DEPTH   (4),
        .CONTROL_ADDR (63)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .commit_req     (commit_req),
        .user_interrupt (user_interrupt),
        .bitmap_wr_en   (bitmap_wr_en),
        .underrun_count (underrun_count),
        .batch_count    (batch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge, then let inputs settle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push_cmd(input logic [2:0] idx, input logic [31:0] data);
        bus.cmd_valid = 1'b1;
        bus.cmd_index = idx;
        bus.cmd_data  = data;
        settle();
        check("push_ready", 32'(bus.cmd_ready), 32'd1);
        next_cycle();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic check_word(input string tag, input logic [5:0] addr, input logic [31:0] data);
        check({tag, "_wr_n"}, 32'(bus.spr_write_n), 32'h2);
        check({tag, "_addr"}, 32'(bus.spr_address), 32'(addr));
        check({tag, "_data"}, bus.spr_data_in, data);
        check({tag, "_busy"}, 32'(bus.cpu_busy), 32'd1);
    endtask

    task automatic check_ctrl(input string tag, input logic [31:0] data);
        check({tag, "_wr_n"}, 32'(bus.spr_write_n), 32'h0);
        check({tag, "_addr"}, 32'(bus.spr_address), 32'd63);
        check({tag, "_data"}, bus.spr_data_in, data);
    endtask

    initial begin
        rst_n              = 1'b0;
        commit_req         = 1'b0;
        user_interrupt     = 1'b0;
        bitmap_wr_en       = 1'b1;
        bus.cmd_valid      = 1'b0;
        bus.cmd_index      = '0;
        bus.cmd_data       = '0;
        bus.cpu_address    = '0;
        bus.cpu_data_in    = '0;
        bus.cpu_write_n    = 2'b11;
        bus.cpu_read_n     = 2'b11;
        bus.spr_data_out   = '0;
        bus.spr_data_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_wr_n",     32'(bus.spr_write_n), 32'h3);
        check("rst_rd_n",     32'(bus.spr_read_n),  32'h3);
        check("rst_ready",    32'(bus.cmd_ready),   32'd1);
        check("rst_busy",     32'(bus.cpu_busy),    32'd0);
        check("rst_underrun", 32'(underrun_count),  32'd0);
        check("rst_batch",    32'(batch_count),     32'd0);
        rst_n = 1'b1;
        next_cycle();

        // ---- idle read pass-through ----
        bus.cpu_read_n     = 2'b10;
        bus.cpu_address    = 6'd12;
        bus.spr_data_out   = 32'hCAFE_F00D;
        bus.spr_data_ready = 1'b1;
        settle();
        check("idle_rd_n",   32'(bus.spr_read_n),     32'h2);
        check("idle_raddr",  32'(bus.spr_address),    32'd12);
        check("idle_rdata",  bus.cpu_data_out,        32'hCAFE_F00D);
        check("idle_rready", 32'(bus.cpu_data_ready), 32'd1);
        next_cycle();
        bus.cpu_read_n     = 2'b11;
        bus.cpu_address    = '0;
        bus.spr_data_ready = 1'b0;
        bus.spr_data_out   = '0;

        // ---- basic batch: idx 0,2,5 via user_interrupt ----
        push_cmd(3'd0, 32'hA000_0000);
        push_cmd(3'd2, 32'hA222_2222);
        push_cmd(3'd5, 32'hA555_5555);
        user_interrupt = 1'b1;                       // cycle N
        settle();
        check("a_trig_busy", 32'(bus.cpu_busy), 32'd0);
        next_cycle();
        user_interrupt = 1'b0;
        bus.spr_data_ready = 1'b1;                   // must not reach host
        settle();
        check_word("a_w1", 6'd0, 32'hA000_0000);     // N+1
        check("a_w1_rready", 32'(bus.cpu_data_ready), 32'd0);
        next_cycle();
        bus.spr_data_ready = 1'b0;
        settle();
        check_word("a_w2", 6'd8, 32'hA222_2222);     // N+2
        next_cycle();
        check_word("a_w3", 6'd20, 32'hA555_5555);    // N+3
        next_cycle();
        check_ctrl("a_ctl", 32'h0000_0003);          // N+4
        next_cycle();
        check("a_idle_busy", 32'(bus.cpu_busy),    32'd0);  // N+5
        check("a_idle_wr_n", 32'(bus.spr_write_n), 32'h3);
        check("a_batch",     32'(batch_count),     32'd1);
        check("a_underrun",  32'(underrun_count),  32'd0);

        // ---- underrun with empty FIFO ----
        user_interrupt = 1'b1;
        settle();
        check("u1_wr_n", 32'(bus.spr_write_n), 32'h3);
        next_cycle();
        user_interrupt = 1'b0;
        next_cycle();
        user_interrupt = 1'b1;
        next_cycle();
        user_interrupt = 1'b0;
        settle();
        check("u2_wr_n",  32'(bus.spr_write_n), 32'h3);
        check("u2_busy",  32'(bus.cpu_busy),    32'd0);
        check("u2_count", 32'(underrun_count),  32'd2);
        // coincident commit_req suppresses the underrun
        user_interrupt = 1'b1;
        commit_req     = 1'b1;
        next_cycle();
        user_interrupt = 1'b0;
        commit_req     = 1'b0;
        settle();
        check("u_both_count", 32'(underrun_count), 32'd2);
        check("u_both_busy",  32'(bus.cpu_busy),   32'd0);
        // 298 further pulses -> 300 total, saturates
        user_interrupt = 1'b1;
        repeat (298) next_cycle();
        user_interrupt = 1'b0;
        settle();
        check("u_sat", 32'(underrun_count), 32'd255);
        next_cycle();

        // ---- full FIFO, commit_req, push during DRAIN, duplicate index ----
        push_cmd(3'd1, 32'hC000_0001);
        push_cmd(3'd3, 32'hC000_0003);
        push_cmd(3'd1, 32'hC111_1111);
        push_cmd(3'd7, 32'hC000_0007);
        settle();
        check("c_full_ready", 32'(bus.cmd_ready), 32'd0);
        commit_req = 1'b1;                           // N
        next_cycle();
        commit_req = 1'b0;
        settle();
        check_word("c_w1", 6'd4, 32'hC000_0001);     // N+1
        check("c_w1_ready", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;                        // push during DRAIN
        bus.cmd_index = 3'd6;
        bus.cmd_data  = 32'hD666_6666;
        next_cycle();
        bus.cmd_valid = 1'b0;
        settle();
        check_word("c_w2", 6'd12, 32'hC000_0003);    // N+2
        next_cycle();
        check_word("c_w3", 6'd4, 32'hC111_1111);     // N+3
        next_cycle();
        check_word("c_w4", 6'd28, 32'hC000_0007);    // N+4
        next_cycle();
        check_ctrl("c_ctl", 32'h0000_0003);          // N+5
        next_cycle();
        check("c_idle_busy", 32'(bus.cpu_busy), 32'd0);
        check("c_batch",     32'(batch_count),  32'd2);
        bitmap_wr_en = 1'b0;
        commit_req   = 1'b1;                         // flush the held push
        next_cycle();
        commit_req = 1'b0;
        settle();
        check_word("c_next", 6'd24, 32'hD666_6666);
        next_cycle();
        check_ctrl("c_next_ctl", 32'h0000_0002);
        next_cycle();
        check("c_next_batch", 32'(batch_count), 32'd3);
        bitmap_wr_en = 1'b1;

        // ---- host write held during DRAIN ----
        push_cmd(3'd2, 32'hE222_2222);
        commit_req = 1'b1;                           // N
        next_cycle();
        commit_req      = 1'b0;
        bus.cpu_write_n = 2'b10;
        bus.cpu_address = 6'd32;
        bus.cpu_data_in = 32'h0000_1234;
        settle();
        check_word("d_w1", 6'd8, 32'hE222_2222);     // N+1, not forwarded
        next_cycle();
        check("d_ctl_addr", 32'(bus.spr_address), 32'd63);
        check("d_ctl_busy", 32'(bus.cpu_busy),    32'd1);
        next_cycle();
        check("d_fwd_busy", 32'(bus.cpu_busy),    32'd0);
        check("d_fwd_wr_n", 32'(bus.spr_write_n), 32'h2);
        check("d_fwd_addr", 32'(bus.spr_address), 32'd32);
        check("d_fwd_data", bus.spr_data_in,      32'h0000_1234);
        next_cycle();
        bus.cpu_write_n = 2'b11;
        bus.cpu_address = '0;
        bus.cpu_data_in = '0;

        // ---- reset during second DRAIN write ----
        push_cmd(3'd4, 32'hF444_4444);
        push_cmd(3'd5, 32'hF555_5555);
        push_cmd(3'd6, 32'hF666_6666);
        user_interrupt = 1'b1;                       // N
        next_cycle();
        user_interrupt = 1'b0;
        next_cycle();
        check_word("e_w2", 6'd20, 32'hF555_5555);    // N+2
        #1;
        rst_n = 1'b0;
        #1;
        check("e_rst_wr_n",     32'(bus.spr_write_n), 32'h3);
        check("e_rst_busy",     32'(bus.cpu_busy),    32'd0);
        check("e_rst_batch",    32'(batch_count),     32'd0);
        check("e_rst_underrun", 32'(underrun_count),  32'd0);
        check("e_rst_ready",    32'(bus.cmd_ready),   32'd1);
        next_cycle();
        check("e_rst_hold_wr_n", 32'(bus.spr_write_n), 32'h3);
        rst_n = 1'b1;
        next_cycle();
        check("e_post_wr_n", 32'(bus.spr_write_n), 32'h3);
        commit_req = 1'b1;                           // FIFO must be empty
        next_cycle();
        commit_req = 1'b0;
        settle();
        check("e_empty_busy",  32'(bus.cpu_busy),    32'd0);
        check("e_empty_wr_n",  32'(bus.spr_write_n), 32'h3);
        check("e_empty_batch", 32'(batch_count),     32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
